// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared defaults and FSM state type for the pipelined data memory
package datapath_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 8;
  localparam int INIT_VALUE_DEF = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port array, synchronous write and registered read
module dmem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // The array has no reset; only the output register does.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// rtl/pipelined_data_memory.sv - MEM-stage data memory with 1-cycle loads and zero-fill init sequencer
module pipelined_data_memory
  import datapath_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(INIT_VALUE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign accept = req_valid && req_ready;

  // During INIT the sequencer owns the port; requests are dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    if (state == ST_INIT) begin
      ram_we    = 1'b1;
      ram_addr  = cnt;
      ram_wdata = INIT_VALUE;
    end else if (accept) begin
      ram_we = req_we;
      ram_re = !req_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= accept && !req_we;
      if (state == ST_INIT) begin
        cnt <= cnt + ADDR_W'(1);
        if (cnt == '1) begin
          state     <= ST_RUN;
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      end
    end
  end

  dmem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(rsp_rdata)
  );

endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb/tb_pipelined_data_memory.sv - scoreboard bench for 8x256 and 16x16 data memory instances
module tb_pipelined_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_valid, a_we, a_ready, a_rvalid, a_done;
  logic [7:0]  a_addr, a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rvalid, b_done;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;

  pipelined_data_memory u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .init_done(a_done)
  );

  pipelined_data_memory #(.DATA_W(16), .ADDR_W(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .init_done(b_done)
  );

  typedef struct {
    logic        valid;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  bit          sel      = 1'b0;
  int          depth    = 256;
  int          edges    = 0;
  logic [15:0] model [256];
  logic [15:0] last;

  logic        m_valid, m_ready, m_done;
  logic [15:0] m_rdata;
  assign m_valid = sel ? b_rvalid : a_rvalid;
  assign m_ready = sel ? b_ready  : a_ready;
  assign m_done  = sel ? b_done   : a_done;
  assign m_rdata = sel ? b_rdata  : {8'h00, a_rdata};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rsp_valid", {15'h0, m_valid}, {15'h0, e.valid});
      check("rsp_rdata", m_rdata, e.data);
    end else begin
      check("rsp_valid_idle", {15'h0, m_valid}, 16'h0);
    end
  end

  task automatic idle_inputs();
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic model_reset();
    edges = 0;
    last  = '0;
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  task automatic drive(input bit v, input bit we, input int addr, input int data);
    if (sel) begin
      b_valid = v; b_we = we; b_addr = addr[3:0]; b_wdata = data[15:0];
    end else begin
      a_valid = v; a_we = we; a_addr = addr[7:0]; a_wdata = data[7:0];
    end
  endtask

  // Called at a negedge; drives one request, predicts its outcome, returns at the next negedge.
  task automatic issue(input bit v, input bit we, input int addr_in, input int data_in);
    bit ready_exp;
    int addr;
    int data;
    ready_exp = (edges >= depth);
    addr = addr_in & (depth - 1);
    data = data_in & (sel ? 32'hFFFF : 32'h00FF);
    check("req_ready", {15'h0, m_ready}, {15'h0, ready_exp});
    check("init_done", {15'h0, m_done}, {15'h0, ready_exp});
    drive(v, we, addr, data);
    if (v && ready_exp && we) model[addr] = data[15:0];
    if (v && ready_exp && !we) begin
      last = model[addr];
      q.push_back('{1'b1, last});
    end else begin
      q.push_back('{1'b0, last});
    end
    edges++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Load in flight, then async reset between edges; the in-flight load must never answer.
  task automatic mid_reset();
    issue(1'b1, 1'b0, $urandom, 0);
    drive(1'b1, 1'b0, 'h10, 0);
    #2 reset = 1'b1;
    #1 check("rsp_valid_async_reset", {15'h0, m_valid}, 16'h0);
    q.delete();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic init_window(input int n);
    for (int i = 0; i < n; i++)
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    sel   = 1'b0;
    depth = 256;
    do_reset();

    issue(1'b1, 1'b1, 'h20, 'h55);
    init_window(255);

    issue(1'b1, 1'b0, 'h00, 0);
    issue(1'b1, 1'b0, 'h7F, 0);
    issue(1'b1, 1'b0, 'hFF, 0);
    issue(1'b1, 1'b0, 'h20, 0);
    issue(1'b1, 1'b1, 'h10, 'hA5);
    issue(1'b1, 1'b0, 'h10, 0);
    issue(1'b1, 1'b1, 'h11, 'h3C);
    issue(1'b1, 1'b0, 'h10, 0);
    issue(1'b1, 1'b0, 'h11, 0);
    issue(1'b0, 1'b0, 0, 0);
    issue(1'b0, 1'b1, 0, 0);
    issue(1'b1, 1'b1, 'hFF, 'hFF);
    issue(1'b1, 1'b1, 'h00, 'h01);
    issue(1'b1, 1'b0, 'hFF, 0);
    issue(1'b1, 1'b0, 'h00, 0);
    random_run(300);

    mid_reset();
    init_window(256);
    issue(1'b1, 1'b0, 'h10, 0);
    issue(1'b0, 1'b0, 0, 0);

    sel   = 1'b1;
    depth = 16;
    do_reset();
    init_window(16);
    issue(1'b1, 1'b1, 'hF, 'hBEEF);
    issue(1'b1, 1'b0, 'hF, 0);
    issue(1'b1, 1'b0, 'h0, 0);
    random_run(200);
    mid_reset();
    init_window(16);
    issue(1'b1, 1'b0, 'h0, 0);
    issue(1'b0, 1'b0, 0, 0);
    issue(1'b0, 1'b0, 0, 0);

    check("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
